wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
// - Writeback stage feeding the CPU's single register-file write port (32 x 32b, r0 reads as zero).
// - Merges two result producers: the single-cycle ALU pipe (cannot stall) and the variable-latency load unit (ready/valid).
// - Buffers load results in a small FIFO, registers the selected write, and returns bypass/busy info to decode.
// PARAMETERS
// - DEPTH  4   load-result FIFO entries (power of 2, >=2)
// - AW     5   register address width
// - DW     32  data width
// PORTS
// - clk         in   1      clock, rising edge
// - rst         in   1      synchronous reset, active-high
// - alu_valid   in   1      ALU result valid this cycle
// - alu_rd      in   AW     ALU destination register
// - alu_data    in   DW     ALU result
// - ld_valid    in   1      load result offered
// - ld_ready    out  1      load result accepted when ld_valid & ld_ready
// - ld_rd       in   AW     load destination register
// - ld_data     in   DW     load data
// - rf_wr_en    out  1      to reg file wr_en
// - rf_wr_addr  out  AW     to reg file wr_addr
// - rf_wr_data  out  DW     to reg file wr_data
// - rd0_addr    in   AW     decode read port 0 address (same as reg-file rd0_addr)
// - rd1_addr    in   AW     decode read port 1 address
// - byp0_hit    out  1      rd0_addr matches write staged in output register
// - byp1_hit    out  1      as byp0_hit, port 1
// - byp_data    out  DW     staged write data (= rf_wr_data)
// - busy0       out  1      rd0_addr is destination of a load still in FIFO; decode must stall
// - busy1       out  1      as busy0, port 1
// BEHAVIOUR
// - Reset (synchronous, active-high): FIFO emptied, output register invalid; rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, ld_ready=1 from first cycle after reset, byp*/busy* = 0.
// - rst mid-operation: all buffered load results discarded, no write issued in the cycle following reset.
// - Output register (wb_v, wb_rd, wb_data) loaded every cycle; rf_wr_* driven directly from it.
// - Select priority each cycle: ALU if alu_valid, else FIFO head if non-empty, else nothing (wb_v<=0, addr/data hold).
// - Writes to r0 suppressed: alu_rd==0 -> treated as !alu_valid; ld_rd==0 accepted (handshake completes) but not pushed.
// - Latency: ALU result in cycle N -> rf_wr_en=1 in N+1 -> reg file updated at edge ending N+1.
// - Load accepted in cycle N with FIFO empty and no ALU in N+1 -> rf_wr_en=1 in N+2.
// - Head pop only when selected; FIFO keeps arrival order; ALU never stalls, may starve FIFO indefinitely.
// - ld_ready = !full, registered state only (no same-cycle pop credit); push and pop same cycle allowed when not full.
// - Count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
// - byp0_hit = wb_v & (rd0_addr==wb_rd) & (rd0_addr!=0); byp1_hit likewise; combinational on current state.
// - busyN = rdN_addr!=0 & any valid FIFO entry with rd==rdN_addr; combinational, current state (load being accepted this cycle not included).
// - WAW ordering between ALU and load to same rd guaranteed upstream by decode honouring busy0/busy1; not checked here.
// STRUCTURE
// - cpu_pkg: XLEN=32, REG_AW=5, typedef wb_entry_t {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;}.
// - Sub-module wb_fifo: sync FIFO of wb_entry_t, DEPTH param, push/pop/full/empty, plus per-entry valid+rd vector exported for busy compare.
// - Top: r0 filter, priority select, output register, bypass and busy comparators.
// TESTING
// - Reset: rst=1 two cycles with ld/alu valid -> rf_wr_en=0, ld_ready=1, no FIFO push; release -> idle outputs 0.
// - ALU only: alu_valid rd=3 data=0x0000_00AA cycle N -> rf_wr_en=1 addr=3 data=0xAA cycle N+1, byp0_hit=1 when rd0_addr=3.
// - Load path: ld rd=7 data=0x1234_5678 accepted N, no ALU -> busy0=1 for rd0_addr=7 in N+1, rf write rd=7 in N+2, busy0=0 in N+2.
// - Contention: 4 loads rd=1..4 back-to-back while ALU valid 6 cycles -> ld_ready=0 after 4th, ALU writes first, loads then drain rd 1,2,3,4 in order.
// - r0: alu_rd=0 and ld_rd=0 -> handshake completes, rf_wr_en never asserted, byp/busy stay 0 for rd0_addr=0.
// - Reset mid-drain: FIFO holding 3 entries, rst=1 one cycle -> no further rf writes, ld_ready=1, busy0/busy1=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths and the writeback entry type
// Purpose: CPU-wide widths and the record carried through the load-result FIFO.
package wb_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter signal bundle
// Purpose: groups the ALU result, load handshake, register-file write,
// and decode bypass/busy signals of the writeback stage.
// Ports (slave = arbiter side):
//   in : alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rd0_addr, rd1_addr
//   out: ld_ready, rf_wr_en, rf_wr_addr, rf_wr_data, byp0_hit, byp1_hit, byp_data, busy0, busy1
interface wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic [AW-1:0] rd0_addr;
    logic [AW-1:0] rd1_addr;
    logic          byp0_hit;
    logic          byp1_hit;
    logic [DW-1:0] byp_data;
    logic          busy0;
    logic          busy1;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rd0_addr, rd1_addr,
        output ld_ready, rf_wr_en, rf_wr_addr, rf_wr_data, byp0_hit, byp1_hit, byp_data,
               busy0, busy1
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rd0_addr, rd1_addr,
        input  ld_ready, rf_wr_en, rf_wr_addr, rf_wr_data, byp0_hit, byp1_hit, byp_data,
               busy0, busy1
    );
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of load results with per-entry rd export
// Purpose: holds accepted load results in arrival order until writeback.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_entry    write an entry (ignored when full)
//   pop, head_entry     consume the head entry (ignored when empty)
//   full, empty         occupancy flags from registered state
//   ent_valid, ent_rd   per-slot occupancy and destination, for busy compare
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    output wb_entry_t                    head_entry,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH-1:0][REG_AW-1:0] ent_rd
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_entry = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (do_push) begin
                wr_ptr            <= wr_ptr + PW'(1);
                ent_valid[wr_ptr] <= 1'b1;
            end
            // Same slot cannot be pushed and popped in one cycle: that needs
            // wr_ptr==rd_ptr, which only happens when empty or full.
            if (do_pop) begin
                rd_ptr            <= rd_ptr + PW'(1);
                ent_valid[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; ent_valid qualifies every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_comb begin
        ent_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_rd[i] = mem[i].rd;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback stage merging ALU and load results
// Purpose: feeds the single register-file write port from the non-stalling
// ALU pipe (priority) and a buffered load unit; reports bypass and busy to decode.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        wb_arbiter_if.slave: ALU result, load ready/valid, rf write,
//              decode read addresses, bypass hits/data, busy flags
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    logic                         alu_eff;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic                         empty;
    wb_entry_t                    push_entry;
    wb_entry_t                    head_entry;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][REG_AW-1:0] ent_rd;

    logic          wb_v;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    // r0 writes are dropped: an ALU write to r0 is simply not a write, and a
    // load to r0 still completes its handshake but never enters the FIFO.
    assign alu_eff = bus.alu_valid & (bus.alu_rd != '0);
    assign push    = bus.ld_valid & ~full & (bus.ld_rd != '0);
    assign pop     = ~alu_eff & ~empty;

    assign push_entry.rd   = bus.ld_rd;
    assign push_entry.data = bus.ld_data;

    // No same-cycle pop credit, keeping ld_ready off the ALU timing path.
    assign bus.ld_ready = ~full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .full       (full),
        .empty      (empty),
        .ent_valid  (ent_valid),
        .ent_rd     (ent_rd)
    );

    // Address/data hold when nothing is selected so bypass data stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_v    <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (alu_eff) begin
            wb_v    <= 1'b1;
            wb_rd   <= bus.alu_rd;
            wb_data <= bus.alu_data;
        end else if (!empty) begin
            wb_v    <= 1'b1;
            wb_rd   <= head_entry.rd;
            wb_data <= head_entry.data;
        end else begin
            wb_v    <= 1'b0;
        end
    end

    assign bus.rf_wr_en   = wb_v;
    assign bus.rf_wr_addr = wb_rd;
    assign bus.rf_wr_data = wb_data;
    assign bus.byp_data   = wb_data;

    assign bus.byp0_hit = wb_v & (bus.rd0_addr == wb_rd) & (bus.rd0_addr != '0);
    assign bus.byp1_hit = wb_v & (bus.rd1_addr == wb_rd) & (bus.rd1_addr != '0);

    always_comb begin
        bus.busy0 = 1'b0;
        bus.busy1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && ent_rd[i] == bus.rd0_addr && bus.rd0_addr != '0) begin
                bus.busy0 = 1'b1;
            end
            if (ent_valid[i] && ent_rd[i] == bus.rd1_addr && bus.rd1_addr != '0) begin
                bus.busy1 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.AW(5), .DW(32)) bus ();

    wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    wb_entry_t   m_q[$];
    wb_entry_t   exp_q[$];
    logic        m_wb_v    = 1'b0;
    logic [4:0]  m_wb_rd   = '0;
    logic [31:0] m_wb_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic m_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (m_q[i]) if (m_q[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic r,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                        input logic [4:0] a0, input logic [4:0] a1);
        logic      accept;
        wb_entry_t e;
        rst           = r;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_rd     = lrd;
        bus.ld_data   = ldd;
        bus.rd0_addr  = a0;
        bus.rd1_addr  = a1;
        accept = lv && (m_q.size() < DEPTH);
        if (r) begin
            m_q.delete();
            exp_q.delete();
            m_wb_v    = 1'b0;
            m_wb_rd   = '0;
            m_wb_data = '0;
        end else begin
            if (av && ard != 5'd0) begin
                e = wb_entry_t'{rd: ard, data: ad};
                m_wb_v = 1'b1; m_wb_rd = ard; m_wb_data = ad;
                exp_q.push_back(e);
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_wb_v = 1'b1; m_wb_rd = e.rd; m_wb_data = e.data;
                exp_q.push_back(e);
            end else begin
                m_wb_v = 1'b0;
            end
            if (accept && lrd != 5'd0) m_q.push_back(wb_entry_t'{rd: lrd, data: ldd});
        end
        @(posedge clk);
        #1;
        chk("rf_wr_en", 32'(bus.rf_wr_en), 32'(m_wb_v));
        if (m_wb_v && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_wr_addr", 32'(bus.rf_wr_addr), 32'(e.rd));
            chk("rf_wr_data", bus.rf_wr_data, e.data);
            chk("byp_data", bus.byp_data, e.data);
        end
        chk("ld_ready", 32'(bus.ld_ready), 32'(m_q.size() < DEPTH));
        chk("busy0", 32'(bus.busy0), 32'(m_busy(a0)));
        chk("busy1", 32'(bus.busy1), 32'(m_busy(a1)));
        chk("byp0_hit", 32'(bus.byp0_hit), 32'(m_wb_v && a0 == m_wb_rd && a0 != 0));
        chk("byp1_hit", 32'(bus.byp1_hit), 32'(m_wb_v && a1 == m_wb_rd && a1 != 0));
    endtask

    task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a0, a1);
    endtask

    initial begin
        // Reset held two cycles with both producers active.
        step(1'b1, 1'b1, 5'd9, 32'h11, 1'b1, 5'd8, 32'h22, 5'd9, 5'd8);
        step(1'b1, 1'b1, 5'd9, 32'h11, 1'b1, 5'd8, 32'h22, 5'd9, 5'd8);
        chk("rst_wr_addr", 32'(bus.rf_wr_addr), 32'd0);
        chk("rst_wr_data", bus.rf_wr_data, 32'd0);
        idle(5'd8, 5'd9);
        chk("post_rst_busy0", 32'(bus.busy0), 32'd0);

        // ALU only.
        step(1'b0, 1'b1, 5'd3, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        chk("alu_byp0", 32'(bus.byp0_hit), 32'd1);
        chk("alu_addr", 32'(bus.rf_wr_addr), 32'd3);
        idle(5'd3, 5'd0);

        // Load path: busy in N+1, write in N+2.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd0);
        chk("ld_busy0", 32'(bus.busy0), 32'd1);
        idle(5'd7, 5'd0);
        chk("ld_write_data", bus.rf_wr_data, 32'h1234_5678);
        chk("ld_busy0_clear", 32'(bus.busy0), 32'd0);
        idle(5'd7, 5'd0);

        // Contention: ALU for 6 cycles starves the FIFO, then loads drain in order.
        for (int i = 1; i <= 4; i++)
            step(1'b0, 1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'd4);
        chk("full_ld_ready", 32'(bus.ld_ready), 32'd0);
        for (int i = 5; i <= 6; i++)
            step(1'b0, 1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b1, 5'd9, 32'h999, 5'd1, 5'd9);
        for (int i = 0; i < 5; i++) idle(5'd1, 5'd4);

        // r0 on both producers.
        step(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
        chk("r0_ld_ready", 32'(bus.ld_ready), 32'd1);
        idle(5'd0, 5'd0);
        chk("r0_no_write", 32'(bus.rf_wr_en), 32'd0);

        // Reset mid-drain with three loads buffered.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'd20, 32'h50 + 32'(i), 1'b1, 5'(5 + i), 32'h60 + 32'(i), 5'd5, 5'd7);
        step(1'b1, 1'b1, 5'd21, 32'h77, 1'b1, 5'd9, 32'h88, 5'd5, 5'd7);
        chk("mid_rst_busy0", 32'(bus.busy0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle(5'd5, 5'd6);
            chk("mid_rst_no_write", 32'(bus.rf_wr_en), 32'd0);
        end

        // Random mix, including r0 and back-pressure.
        for (int i = 0; i < 80; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        for (int i = 0; i < 6; i++) idle(5'd1, 5'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
